// File: rtl/audio_pair_fifo.sv
// audio_pair_fifo: buffers stereo ADC sample pairs and serialises them as
// left-then-right 12-bit words over a valid/request handshake. Tracks the
// fill level, the number of dropped pairs and a sticky underrun flag.
module audio_pair_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter bit          SIGNED_OUT = 1'b1
) (
  input  logic                  clk_40MHz,
  input  logic                  nReset,
  input  logic [11:0]           audio_left,
  input  logic [11:0]           audio_right,
  input  logic                  audio_ready,
  input  logic                  clear,
  input  logic                  rd_req,
  output logic [11:0]           out_word,
  output logic                  out_is_right,
  output logic                  out_valid,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            overflow_count,
  output logic                  underrun
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LEFT,
    S_RIGHT
  } state_e;

  // Offset-binary to two's complement is a flip of the sign bit.
  function automatic logic [11:0] conv(input logic [11:0] s);
    conv = SIGNED_OUT ? {~s[11], s[10:0]} : s;
  endfunction

  logic [23:0]           ram_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [7:0]            ovf_q, ovf_d;
  logic                  underrun_q, underrun_d;
  state_e                state_q, state_d;
  logic [11:0]           word_q, word_d;
  logic                  right_q, right_d;
  // Only the right half of the popped pair needs holding: the left word goes
  // straight from RAM into the output register on the pop.
  logic [11:0]           rsamp_q, rsamp_d;

  logic [23:0] rd_pair;
  logic        full, empty, pop, wr_en;

  assign rd_pair = ram_q[rd_ptr_q];
  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);

  // Output FSM, FIFO bookkeeping and counters; clear overrides everything.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    right_d    = right_q;
    rsamp_d    = rsamp_q;
    pop        = 1'b0;
    wr_en      = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    underrun_d = underrun_q;

    case (state_q)
      S_EMPTY: begin
        if (!empty) begin
          pop     = 1'b1;
          word_d  = conv(rd_pair[23:12]);
          right_d = 1'b0;
          state_d = S_LEFT;
        end
      end
      S_LEFT: begin
        if (rd_req) begin
          word_d  = conv(rsamp_q);
          right_d = 1'b1;
          state_d = S_RIGHT;
        end
      end
      S_RIGHT: begin
        if (rd_req) begin
          if (!empty) begin
            pop     = 1'b1;
            word_d  = conv(rd_pair[23:12]);
            right_d = 1'b0;
            state_d = S_LEFT;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (pop) begin
      rsamp_d  = rd_pair[11:0];
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // A pop in the same cycle frees the slot being written when full.
    wr_en = audio_ready && (!full || pop);
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else if (audio_ready && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end

    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    if (rd_req && (state_q == S_EMPTY)) begin
      underrun_d = 1'b1;
    end

    if (clear) begin
      state_d    = S_EMPTY;
      word_d     = '0;
      right_d    = 1'b0;
      rsamp_d    = '0;
      pop        = 1'b0;
      wr_en      = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      ovf_d      = '0;
      underrun_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_40MHz or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_EMPTY;
      word_q     <= '0;
      right_q    <= 1'b0;
      rsamp_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      right_q    <= right_d;
      rsamp_q    <= rsamp_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      underrun_q <= underrun_d;
    end
  end

  // Pair storage; contents need no reset.
  always_ff @(posedge clk_40MHz) begin
    if (wr_en) begin
      ram_q[wr_ptr_q] <= {audio_left, audio_right};
    end
  end

  assign out_word       = word_q;
  assign out_is_right   = right_q;
  assign out_valid      = (state_q != S_EMPTY);
  assign fifo_level     = level_q;
  assign overflow_count = ovf_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_audio_pair_fifo.sv
// Bench for audio_pair_fifo: a signed-output and a raw-output instance share
// the same stimulus; a scoreboard of expected words is checked on every
// consumed word, plus explicit status checks at key points.
`timescale 1ns/1ps
module tb_audio_pair_fifo;

  localparam int unsigned DL = 4;

  logic          clk_40MHz = 1'b0;
  logic          nReset = 1'b0;
  logic [11:0]   audio_left = '0;
  logic [11:0]   audio_right = '0;
  logic          audio_ready = 1'b0;
  logic          clear = 1'b0;
  logic          rd_req = 1'b0;

  logic [11:0]   out_word, raw_word;
  logic          out_is_right, raw_is_right;
  logic          out_valid, raw_valid;
  logic [DL:0]   fifo_level, raw_level;
  logic [7:0]    overflow_count, raw_ovf;
  logic          underrun, raw_underrun;

  audio_pair_fifo #(.DEPTH_LOG2(DL), .SIGNED_OUT(1'b1)) u_dut (
    .clk_40MHz(clk_40MHz), .nReset(nReset),
    .audio_left(audio_left), .audio_right(audio_right), .audio_ready(audio_ready),
    .clear(clear), .rd_req(rd_req),
    .out_word(out_word), .out_is_right(out_is_right), .out_valid(out_valid),
    .fifo_level(fifo_level), .overflow_count(overflow_count), .underrun(underrun)
  );

  audio_pair_fifo #(.DEPTH_LOG2(DL), .SIGNED_OUT(1'b0)) u_raw (
    .clk_40MHz(clk_40MHz), .nReset(nReset),
    .audio_left(audio_left), .audio_right(audio_right), .audio_ready(audio_ready),
    .clear(clear), .rd_req(rd_req),
    .out_word(raw_word), .out_is_right(raw_is_right), .out_valid(raw_valid),
    .fifo_level(raw_level), .overflow_count(raw_ovf), .underrun(raw_underrun)
  );

  always #12.5 clk_40MHz = ~clk_40MHz;

  typedef struct packed {
    logic [11:0] word;
    logic        right;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_signed(input logic [11:0] s);
    return {~s[11], s[10:0]};
  endfunction

  task automatic tick();
    @(posedge clk_40MHz);
    #1;
  endtask

  task automatic send(input logic [11:0] l, input logic [11:0] r, input bit accept);
    audio_left  = l;
    audio_right = r;
    audio_ready = 1'b1;
    if (accept) begin
      sb.push_back('{word: l, right: 1'b0});
      sb.push_back('{word: r, right: 1'b1});
    end
    tick();
    audio_ready = 1'b0;
  endtask

  task automatic status(input string tag, input bit v, input int unsigned lvl,
                        input int unsigned ovf, input bit und);
    check_eq({tag, "_valid"},    out_valid, v);
    check_eq({tag, "_rvalid"},   raw_valid, v);
    check_eq({tag, "_level"},    fifo_level, lvl);
    check_eq({tag, "_rlevel"},   raw_level, lvl);
    check_eq({tag, "_ovf"},      overflow_count, ovf);
    check_eq({tag, "_rovf"},     raw_ovf, ovf);
    check_eq({tag, "_underrun"}, underrun, und);
    check_eq({tag, "_runder"},   raw_underrun, und);
  endtask

  task automatic pulse_rd();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    rd_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!out_valid) break;
    end
    rd_req = 1'b0;
    check_eq({tag, "_drain_done"}, out_valid, 1'b0);
  endtask

  // Scoreboard: every word taken by the consumer is compared here.
  always @(negedge clk_40MHz) begin : mon
    exp_t e;
    if (nReset && !clear && rd_req && out_valid) begin
      if (sb.size() == 0) begin
        check_eq("sb_nonempty", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check_eq("word",     out_word, to_signed(e.word));
        check_eq("raw_word", raw_word, e.word);
        check_eq("side",     out_is_right, e.right);
        check_eq("raw_side", raw_is_right, e.right);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) tick();
    status("rst_in", 0, 0, 0, 0);
    check_eq("rst_in_word", out_word, 0);
    nReset = 1'b1;
    tick();
    status("rst", 0, 0, 0, 0);
    check_eq("rst_word", out_word, 0);
    check_eq("rst_side", out_is_right, 0);

    // 1: single pair, latency and sign conversion
    send(12'h800, 12'h7FF, 1'b1);
    status("t1_k", 0, 1, 0, 0);
    tick();
    status("t1_k1", 1, 0, 0, 0);
    check_eq("t1_left", out_word, 12'h000);
    check_eq("t1_left_side", out_is_right, 0);
    pulse_rd();
    check_eq("t1_right", out_word, 12'hFFF);
    check_eq("t1_right_raw", raw_word, 12'h7FF);
    check_eq("t1_right_side", out_is_right, 1);
    pulse_rd();
    status("t1_done", 0, 0, 0, 0);
    check_eq("t1_sb", sb.size(), 0);

    // 2: back-to-back pairs with continuous read
    send(12'h123, 12'h456, 1'b1);
    send(12'h789, 12'hABC, 1'b1);
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_nobubble", out_valid, 1);
      tick();
    end
    rd_req = 1'b0;
    status("t2_end", 0, 0, 0, 0);
    check_eq("t2_sb", sb.size(), 0);

    // 3: overfill without reads
    for (int i = 1; i <= 20; i++) begin
      send(12'(12'h100 + i), 12'(12'hA00 + i), i <= 17);
    end
    status("t3_full", 1, 16, 3, 0);
    check_eq("t3_hold", out_word, to_signed(12'h101));
    check_eq("t3_hold_side", out_is_right, 0);

    // 4: write and pop in the same cycle while full
    pulse_rd();
    check_eq("t4_right", out_is_right, 1);
    rd_req = 1'b1;
    send(12'h5A5, 12'h3C3, 1'b1);
    rd_req = 1'b0;
    status("t4_same", 1, 16, 3, 0);
    check_eq("t4_next", out_word, to_signed(12'h102));
    drain("t4");
    status("t4_drained", 0, 0, 3, 0);
    check_eq("t4_sb", sb.size(), 0);

    // 5: underrun, saturation, clear
    pulse_rd();
    status("t5_underrun", 0, 0, 3, 1);
    send(12'h0F0, 12'h00F, 1'b1);
    tick();
    drain("t5a");
    check_eq("t5_sticky", underrun, 1);
    for (int i = 0; i < 279; i++) begin
      send(12'(i), 12'(~i), i < 17);
    end
    status("t5_sat", 1, 16, 255, 1);
    clear       = 1'b1;
    audio_left  = 12'hDEA;
    audio_right = 12'hBEE;
    audio_ready = 1'b1;
    tick();
    clear       = 1'b0;
    audio_ready = 1'b0;
    sb.delete();
    status("t5_clr", 0, 0, 0, 0);
    check_eq("t5_clr_word", out_word, 0);
    check_eq("t5_clr_side", out_is_right, 0);
    tick();
    status("t5_clr2", 0, 0, 0, 0);

    // 6: asynchronous reset mid-operation
    for (int i = 0; i < 6; i++) begin
      send(12'(12'h300 + i), 12'(12'h600 + i), 1'b1);
    end
    status("t6_fill", 1, 5, 0, 0);
    check_eq("t6_fill_side", out_is_right, 0);
    #3;
    nReset = 1'b0;
    #1;
    status("t6_async", 0, 0, 0, 0);
    check_eq("t6_async_word", out_word, 0);
    check_eq("t6_async_side", out_is_right, 0);
    sb.delete();
    tick();
    tick();
    nReset = 1'b1;
    send(12'hE11, 12'h1EE, 1'b1);
    status("t6_k", 0, 1, 0, 0);
    tick();
    status("t6_k1", 1, 0, 0, 0);
    check_eq("t6_new", out_word, to_signed(12'hE11));
    pulse_rd();
    pulse_rd();
    status("t6_done", 0, 0, 0, 0);

    check_eq("sb_final", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
